// File: rtl/adder_error_sweeper.sv
// Exhaustive sweep engine for a combinational approximate adder: walks every
// operand pair, registers the per-pair error, and accumulates error statistics.
module adder_error_sweeper #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [WIDTH:0]     approx_sum,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   total_cases,
  output logic [2*WIDTH:0]   error_count,
  output logic [3*WIDTH+2:0] error_sum,
  output logic [3*WIDTH+1:0] abs_error_sum,
  output logic [4*WIDTH+2:0] sq_error_sum,
  output logic [WIDTH+1:0]   max_abs_error,
  output logic [1:0]         state
);

  localparam int IDX_W   = 2 * WIDTH;
  localparam int N_CASES = 2 ** IDX_W;
  localparam int ERR_W   = WIDTH + 2;
  localparam int SQ_W    = 2 * WIDTH + 3;
  localparam int TC_W    = 2 * WIDTH + 1;
  localparam int ES_W    = 3 * WIDTH + 3;
  localparam int AS_W    = 3 * WIDTH + 2;
  localparam int SS_W    = 4 * WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            fsm;
  logic [IDX_W-1:0]  idx;

  logic [WIDTH:0]    exact;
  logic [ERR_W-1:0]  err;
  logic [ERR_W-1:0]  abs_err;
  logic [SQ_W-1:0]   sq_err;

  logic              s1_valid;
  logic              s1_flag;
  logic [ERR_W-1:0]  s1_err;
  logic [ERR_W-1:0]  s1_abs;
  logic [SQ_W-1:0]   s1_sq;

  // Index is {A,B}: B is the inner loop, A the outer.
  assign a_out = idx[IDX_W-1:WIDTH];
  assign b_out = idx[WIDTH-1:0];
  assign state = fsm;

  // Both operands are zero-extended to ERR_W so the difference is a valid signed value.
  always_comb begin
    exact   = {1'b0, a_out} + {1'b0, b_out};
    err     = {1'b0, approx_sum} - {1'b0, exact};
    abs_err = err[ERR_W-1] ? -err : err;
    sq_err  = {{(SQ_W-ERR_W){1'b0}}, abs_err} * {{(SQ_W-ERR_W){1'b0}}, abs_err};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm           <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      total_cases   <= '0;
      error_count   <= '0;
      error_sum     <= '0;
      abs_error_sum <= '0;
      sq_error_sum  <= '0;
      max_abs_error <= '0;
      s1_valid      <= 1'b0;
      s1_flag       <= 1'b0;
      s1_err        <= '0;
      s1_abs        <= '0;
      s1_sq         <= '0;
    end else begin
      if (s1_valid) begin
        total_cases   <= total_cases + TC_W'(1);
        error_count   <= error_count + TC_W'(s1_flag);
        error_sum     <= error_sum + {{(ES_W-ERR_W){s1_err[ERR_W-1]}}, s1_err};
        abs_error_sum <= abs_error_sum + {{(AS_W-ERR_W){1'b0}}, s1_abs};
        sq_error_sum  <= sq_error_sum + {{(SS_W-SQ_W){1'b0}}, s1_sq};
        if (s1_abs > max_abs_error) max_abs_error <= s1_abs;
      end

      s1_valid <= (fsm == RUN);
      if (fsm == RUN) begin
        s1_flag <= (err != '0);
        s1_err  <= err;
        s1_abs  <= abs_err;
        s1_sq   <= sq_err;
      end

      case (fsm)
        IDLE, DONE: begin
          if (start) begin
            fsm           <= RUN;
            idx           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            total_cases   <= '0;
            error_count   <= '0;
            error_sum     <= '0;
            abs_error_sum <= '0;
            sq_error_sum  <= '0;
            max_abs_error <= '0;
          end
        end
        RUN: begin
          // The last pair is still sampled this cycle; the index wraps back to 0.
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(N_CASES - 1)) fsm <= DRAIN;
        end
        DRAIN: begin
          fsm  <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_error_sweeper.sv
// Bench for adder_error_sweeper: a 4-bit instance for the directed scenarios
// and an 8-bit instance for one full truncated-adder sweep.
module tb_adder_error_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // 4-bit instance
  logic        start4 = 1'b0;
  logic [3:0]  a4, b4;
  logic [4:0]  approx4;
  logic        busy4, done4;
  logic [8:0]  tc4, ec4;
  logic [14:0] es4;
  logic [13:0] as4;
  logic [18:0] ss4;
  logic [5:0]  mx4;
  logic [1:0]  st4;
  int          mode4 = 0;

  // 8-bit instance
  logic        start8 = 1'b0;
  logic [7:0]  a8, b8;
  logic [8:0]  approx8;
  logic        busy8, done8;
  logic [16:0] tc8, ec8;
  logic [26:0] es8;
  logic [25:0] as8;
  logic [34:0] ss8;
  logic [9:0]  mx8;
  logic [1:0]  st8;

  adder_error_sweeper #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_out(a4), .b_out(b4),
    .approx_sum(approx4), .busy(busy4), .done(done4), .total_cases(tc4),
    .error_count(ec4), .error_sum(es4), .abs_error_sum(as4),
    .sq_error_sum(ss4), .max_abs_error(mx4), .state(st4)
  );

  adder_error_sweeper #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_out(a8), .b_out(b8),
    .approx_sum(approx8), .busy(busy8), .done(done8), .total_cases(tc8),
    .error_count(ec8), .error_sum(es8), .abs_error_sum(as8),
    .sq_error_sum(ss8), .max_abs_error(mx8), .state(st8)
  );

  // Adder models under test
  always_comb begin
    logic [4:0] s4;
    s4 = {1'b0, a4} + {1'b0, b4};
    case (mode4)
      1:       approx4 = s4 | 5'd1;
      2:       approx4 = s4 & 5'h1C;
      3:       approx4 = 5'd31;
      default: approx4 = s4;
    endcase
  end

  always_comb approx8 = ({1'b0, a8} + {1'b0, b8}) & 9'h1F0;

  task automatic check(input string tag, input logic signed [63:0] got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a 4-bit sweep, optionally pulse start again at two cycle offsets, and return latency.
  task automatic sweep4(input string tag, input int m, input int p1, input int p2, output int lat);
    mode4 = m;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check({tag, "_busy0"}, busy4, 1);
    check({tag, "_done0"}, done4, 0);
    check({tag, "_state0"}, st4, 1);
    lat = 0;
    while (!done4 && lat < 1000) begin
      start4 = (lat == p1) || (lat == p2);
      @(posedge clk);
      #1;
      lat++;
    end
    start4 = 1'b0;
    check({tag, "_latency"}, lat, 257);
    check({tag, "_busy_end"}, busy4, 0);
  endtask

  task automatic expect4(input string tag, input longint tc, input longint ec, input longint es,
                         input longint as, input longint ss, input longint mx);
    check({tag, "_total"}, tc4, tc);
    check({tag, "_errcnt"}, ec4, ec);
    check({tag, "_errsum"}, $signed(es4), es);
    check({tag, "_abssum"}, as4, as);
    check({tag, "_sqsum"}, ss4, ss);
    check({tag, "_maxabs"}, mx4, mx);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", st4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_a", a4, 0);
    check("rst_b", b4, 0);
    expect4("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    sweep4("exact", 0, -1, -1, lat);
    expect4("exact", 256, 0, 0, 0, 0, 0);
    check("exact_done_state", st4, 3);

    sweep4("or1", 1, -1, -1, lat);
    expect4("or1", 256, 128, 128, 128, 128, 1);

    sweep4("trunc", 2, -1, -1, lat);
    expect4("trunc", 256, 192, -384, 384, 896, 3);

    sweep4("const", 3, -1, -1, lat);
    expect4("const", 256, 256, 4096, 4096, 76416, 31);

    sweep4("midstart", 1, 10, 200, lat);
    expect4("midstart", 256, 128, 128, 128, 128, 1);
    sweep4("rerun", 1, -1, -1, lat);
    expect4("rerun", 256, 128, 128, 128, 128, 1);

    // Asynchronous reset in the middle of a sweep
    mode4 = 2;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_state", st4, 0);
    check("arst_a", a4, 0);
    check("arst_b", b4, 0);
    expect4("arst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    sweep4("after_rst", 2, -1, -1, lat);
    expect4("after_rst", 256, 192, -384, 384, 896, 3);

    // Full 8-bit sweep with the lower four sum bits truncated
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check("w8_busy0", busy8, 1);
    lat = 0;
    while (!done8 && lat < 70000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w8_latency", lat, 65537);
    check("w8_total", tc8, 65536);
    check("w8_errcnt", ec8, 61440);
    check("w8_errsum", $signed(es8), -491520);
    check("w8_abssum", as8, 491520);
    check("w8_sqsum", ss8, 5079040);
    check("w8_maxabs", mx8, 15);
    check("w8_busy_end", busy8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_error_sweeper.md
# adder_error_sweeper

Exhaustive sweep-and-measure engine wrapped around a combinational approximate adder (e.g. the 8-bit OLOCA-style adders). It drives every operand pair onto the adder, samples the approximate sum, and accumulates integer error statistics on chip. Software or a thin bench then only divides the totals by the case count to get ER, AE, MAE, MSE and RMSE.

## Interface
Parameters (derived widths are localparams, not overridable):
- WIDTH, 8, operand width of the adder under test; sum width is WIDTH+1
- N_CASES (local), 2^(2*WIDTH), number of operand pairs swept
- ERR_W (local), WIDTH+2, signed per-case error width
- SQ_W (local), 2*WIDTH+3, per-case squared-error width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle or done
- a_out  out  WIDTH  operand A driven to the adder
- b_out  out  WIDTH  operand B driven to the adder
- approx_sum  in  WIDTH+1  adder result; combinational function of a_out/b_out
- busy  out  1  high from the accepted start through the final accumulate
- done  out  1  level; high once results are final, cleared by next start or rst
- total_cases  out  2*WIDTH+1  pairs accumulated
- error_count  out  2*WIDTH+1  pairs with approx_sum != a+b
- error_sum  out  3*WIDTH+3  signed sum of (approx - exact)
- abs_error_sum  out  3*WIDTH+2  sum of |approx - exact|
- sq_error_sum  out  4*WIDTH+3  sum of (approx - exact)^2
- max_abs_error  out  WIDTH+2  largest |approx - exact| seen

## Operation
- Reset values: state IDLE; a_out, b_out, busy, done and every statistic output = 0; pipeline registers = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: clear all accumulators and the index, clear done, set busy, go to RUN. In RUN/DRAIN, start is ignored.
- RUN: the 2*WIDTH-bit index {a_out,b_out} starts at 0. B is the inner loop and A the outer. Each cycle:
  - compute exact = a_out + b_out (WIDTH+1 bits, zero-extended).
  - compute err = approx_sum - exact as signed ERR_W.
  - register err, |err|, err*err (SQ_W, unsigned) and the flag err!=0 into stage 1.
  - increment the index.
- When the index equals N_CASES-1 its pair is still sampled. The index then wraps to 0 and the state goes to DRAIN.
- Stage 2 (accumulate) runs every cycle that stage 1 holds a valid entry:
  - total_cases += 1
  - error_count += flag
  - error_sum += sign-extended err
  - abs_error_sum += |err|
  - sq_error_sum += err^2
  - max_abs_error = max(max_abs_error, |err|)
- DRAIN lasts 1 cycle and accumulates the last stage-1 entry. It then goes to DONE, sets done and clears busy.
- DONE: statistics hold until the next start or rst. a_out/b_out hold at 0.
- Accumulator widths are sized so no overflow is possible for a full sweep. No saturation logic is needed.
- Statistic outputs are the accumulator registers themselves. They are partial while busy and are only guaranteed when done=1.
- rst mid-sweep: immediate return to the reset values. No partial results are retained.

## Timing
- Edge 0 samples start. At edge 0: state=RUN, index=0, busy=1, done=0.
- Pair k (0-based) is driven during cycle k+1 and captured into stage 1 at edge k+1. It is accumulated at edge k+2.
- Last pair (k=N_CASES-1) is captured at edge N_CASES and accumulated at edge N_CASES+1. At that same edge done=1 and busy=0.
- Start-to-done latency is N_CASES+1 cycles: 65537 for WIDTH=8.
- approx_sum must settle within one cycle of a_out/b_out changing. No handshake exists on the adder side.

## Test plan
- Exact adder (approx = a+b), WIDTH=8, start pulse:
  - done rises exactly 65537 cycles after the start edge.
  - total_cases=65536; every other statistic = 0.
- approx = (a+b)|1:
  - error_count=32768, error_sum=32768, abs_error_sum=32768.
  - sq_error_sum=32768, max_abs_error=1.
- approx = (a+b) & 9'h1F0 (lower 4 bits truncated):
  - error_count=61440, error_sum=-491520, abs_error_sum=491520.
  - sq_error_sum=5079040, max_abs_error=15.
- approx = 511 constant:
  - error_count=65536, error_sum=16777216, max_abs_error=511.
- start pulses at cycles 100 and 30000 mid-sweep:
  - both are ignored; done still occurs at start+65537 with unchanged totals.
  - a start after done clears done on the next edge; the second sweep reproduces identical totals.
- rst asserted asynchronously at cycle 40000:
  - all outputs read 0 before the next clock edge.
  - a new start then yields full, correct totals.
